myip_fnd_cntr_s_axi_regs: RTL and testbench
===========================================

Name: myip_fnd_cntr_s_axi_regs

Overview:
AXI4-Lite slave (responder) register file and count engine for the myip_fnd_cntr IP. It sits behind the bfm master_0 / PS interconnect. It accepts single-beat 32-bit writes and reads to four RW control registers and one RO count register. It drives a 14-bit count value to the downstream FND digit decoder. The count is prescaled from ACLK and wraps at a programmable maximum.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, byte address width; map 0x00-0x10
CNT_WIDTH, 14, width of count output (max 9999 fits)

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accept
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accept
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response accept
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accept
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data accept
fnd_cnt  out  14  current count to FND decoder
fnd_tick  out  1  1-cycle pulse on each count increment/wrap

Behaviour:
- Reset (ARESET=1 at a rising edge): all READY/VALID outputs 0, BRESP/RRESP=00, RDATA=0, REG0-3=0, prescaler=0, fnd_cnt=0, fnd_tick=0. Reset mid-transaction abandons it; no B/R is issued afterwards.
- Map: 0x00 REG0 CTRL (bit0 enable; other bits storage only), 0x04 REG1 PRESCALE (terminal value), 0x08 REG2 MAX (wrap value, low 14 bits used), 0x0C REG3 scratch, 0x10 COUNT RO {18'b0, fnd_cnt}. addr[1:0] ignored.
- Write: AWREADY and WREADY pulse high together for exactly one cycle when AWVALID&WVALID are both high, BVALID=0, and both READYs are low. The register updates on that same edge, per byte lane gated by WSTRB. BVALID rises the next cycle and holds until BREADY. Only one write is outstanding. AW without W, or W without AW, waits and is not accepted.
- BRESP: 00 OKAY for 0x00-0x0C. 10 SLVERR for a write to 0x10 or addr>0x10; these writes have no register effect.
- Read: ARREADY pulses one cycle when ARVALID=1, RVALID=0, ARREADY=0. RDATA/RRESP are registered on that edge. RVALID rises the next cycle and holds with stable RDATA until RREADY. Unmapped read returns RDATA=0 with RRESP=10. COUNT read returns fnd_cnt as of the ARREADY edge.
- Simultaneous read and write are independent; both proceed in the same cycle.
- Count engine, active while REG0[0]=1:
  - prescaler counts 0..REG1.
  - When prescaler==REG1: prescaler<=0, fnd_tick=1 the next cycle, fnd_cnt<= (fnd_cnt>=REG2[13:0]) ? 0 : fnd_cnt+1.
  - REG1=0 gives a tick every cycle.
  - REG2=0 holds fnd_cnt at 0, but ticks still occur.
  - A REG2 lowered below the current count forces a wrap to 0 on the next tick.
- Enable=0: prescaler and fnd_cnt hold; fnd_tick=0.
- A write to REG0 with bit1=1 clears prescaler and fnd_cnt on the write edge. The stored bit1 remains readable.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00-0x0C, then read back -> each BRESP=00, RDATA matches, RRESP=00.
- AWVALID asserted 3 cycles before WVALID to 0x0C, data 0xA5A5A5A5, WSTRB=4'b0101 over prior 0 -> READYs pulse only after WVALID; readback 0x00A500A5.
- REG1=3, REG2=5, REG0=1 -> fnd_tick every 4 cycles; fnd_cnt runs 0..5, then 0; read 0x10 matches fnd_cnt.
- Write 0x10 and read 0x14 -> BRESP=10 with COUNT unchanged; RRESP=10, RDATA=0.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA stable; no second AW/AR accepted.
- Assert ARESET during BVALID=1 with fnd_cnt=3 -> next cycle BVALID=0, fnd_cnt=0, REG0-3=0.

Source files
------------

// File: rtl/myip_fnd_cntr_s_axi_regs.sv
// AXI4-Lite register file for myip_fnd_cntr: four RW control registers, one RO count,
// and the prescaled wrap counter that feeds the FND digit decoder.
module myip_fnd_cntr_s_axi_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH          = 14
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [CNT_WIDTH-1:0]            fnd_cnt,
    output logic                            fnd_tick
);

    localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IDXW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned NB   = DW / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [DW-1:0]        regs [4];
    logic [DW-1:0]        presc;
    logic [IDXW-1:0]      wr_idx;
    logic [IDXW-1:0]      rd_idx;
    logic                 wr_fire;
    logic                 wr_ok;
    logic                 rd_fire;
    logic                 cnt_clr;
    logic [DW-1:0]        rd_data_c;
    logic [1:0]           rd_resp_c;
    logic [CNT_WIDTH-1:0] cnt_max;

    wire unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_ok   = (wr_idx < IDXW'(4));
    assign rd_fire = S_AXI_ARREADY && S_AXI_ARVALID;
    assign cnt_clr = wr_fire && (wr_idx == IDXW'(0)) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
    assign cnt_max = regs[2][CNT_WIDTH-1:0];

    // Write channel: AW and W are accepted together, one outstanding response at a time.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (wr_fire) begin
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    for (int b = 0; b < int'(NB); b++) begin
                        if (S_AXI_WSTRB[b]) regs[wr_idx[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
            end else begin
                if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY) begin
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b1;
                end
                if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read mux; unmapped addresses return zero with SLVERR.
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        if (rd_idx < IDXW'(4)) begin
            rd_data_c = regs[rd_idx[1:0]];
            rd_resp_c = RESP_OKAY;
        end else if (rd_idx == IDXW'(4)) begin
            rd_data_c = DW'(fnd_cnt);
            rd_resp_c = RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else if (rd_fire) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_data_c;
            S_AXI_RRESP   <= rd_resp_c;
        end else begin
            if (S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY) S_AXI_ARREADY <= 1'b1;
            if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
        end
    end

    // Count engine: prescaler runs 0..REG1, count wraps to 0 once it reaches REG2.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            presc    <= '0;
            fnd_cnt  <= '0;
            fnd_tick <= 1'b0;
        end else if (cnt_clr) begin
            presc    <= '0;
            fnd_cnt  <= '0;
            fnd_tick <= 1'b0;
        end else if (regs[0][0]) begin
            if (presc == regs[1]) begin
                presc    <= '0;
                fnd_tick <= 1'b1;
                fnd_cnt  <= (fnd_cnt >= cnt_max) ? '0 : fnd_cnt + CNT_WIDTH'(1);
            end else begin
                presc    <= presc + DW'(1);
                fnd_tick <= 1'b0;
            end
        end else begin
            fnd_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myip_fnd_cntr_s_axi_regs.sv
// Directed bench for myip_fnd_cntr_s_axi_regs: register access, strobes, count engine,
// error responses, back-pressure and mid-transaction reset.
module tb_myip_fnd_cntr_s_axi_regs;

    logic        clk = 1'b0;
    logic        areset;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [13:0] fnd_cnt;
    logic        fnd_tick;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    myip_fnd_cntr_s_axi_regs dut (
        .ACLK(clk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .fnd_cnt(fnd_cnt), .fnd_tick(fnd_tick)
    );

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Drives one write; returns at #1 after the edge that retires BVALID.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        do begin tick1(); n++; end while (!awready && n < 20);
        tests_run++;
        if (!awready) begin tests_failed++; $display("FAIL write_accept addr=%h awready=%b required 1", addr, awready); end
        tick1();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick1(); n++; end
        resp = bresp;
        bready = 1'b1;
        tick1();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        araddr = addr; arvalid = 1'b1;
        do begin tick1(); n++; end while (!arready && n < 20);
        tests_run++;
        if (!arready) begin tests_failed++; $display("FAIL read_accept addr=%h arready=%b required 1", addr, arready); end
        tick1();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick1(); n++; end
        data = rdata; resp = rresp;
        rready = 1'b1;
        tick1();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) tick1();
        tests_run++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, fnd_cnt, fnd_tick} !== 56'd0) begin
            tests_failed++;
            $display("FAIL reset_state got aw=%b w=%b b=%b ar=%b r=%b bresp=%b rresp=%b rdata=%h cnt=%0d tick=%b required all zero",
                     awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, fnd_cnt, fnd_tick);
        end
        areset = 1'b0;
        tick1();
    endtask

    task automatic test_rw();
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, r);
            tests_run++;
            if (r !== 2'b00) begin tests_failed++; $display("FAIL rw_bresp reg%0d got %b required 00", i, r); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), d, r);
            tests_run++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                tests_failed++;
                $display("FAIL rw_readback reg%0d got %h/%b required %h/00", i, d, r, 32'(i + 1));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h0C, 32'h0, 4'hF, r);
        awaddr = 5'h0C; awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick1();
            tests_run++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                tests_failed++;
                $display("FAIL aw_only_wait cycle%0d awready=%b wready=%b required 0/0", i, awready, wready);
            end
        end
        axi_write(5'h0C, 32'hA5A5A5A5, 4'b0101, r);
        axi_read(5'h0C, d, r);
        tests_run++;
        if (d !== 32'h00A500A5) begin tests_failed++; $display("FAIL strobe_readback got %h required 00a500a5", d); end
    endtask

    task automatic test_count();
        logic [1:0]  r;
        logic [31:0] d;
        int exp_cnt = 0;
        int last = -1;
        int nticks = 0;
        logic [13:0] held;
        axi_write(5'h00, 32'h2, 4'hF, r);
        axi_read(5'h00, d, r);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL clr_bit_readback got %h required 2", d); end
        tests_run++;
        if (fnd_cnt !== 14'd0) begin tests_failed++; $display("FAIL clr_cnt got %0d required 0", fnd_cnt); end
        axi_write(5'h04, 32'd3, 4'hF, r);
        axi_write(5'h08, 32'd5, 4'hF, r);
        axi_write(5'h00, 32'h1, 4'hF, r);
        for (int i = 0; i < 40; i++) begin
            tick1();
            if (fnd_tick) begin
                exp_cnt = (exp_cnt >= 5) ? 0 : exp_cnt + 1;
                if (last >= 0) begin
                    tests_run++;
                    if (i - last != 4) begin tests_failed++; $display("FAIL tick_period got %0d required 4", i - last); end
                end
                last = i;
                nticks++;
            end
            tests_run++;
            if (fnd_cnt !== 14'(exp_cnt)) begin
                tests_failed++;
                $display("FAIL count_seq cycle%0d got %0d required %0d", i, fnd_cnt, exp_cnt);
            end
        end
        tests_run++;
        if (nticks < 9) begin tests_failed++; $display("FAIL tick_count got %0d required >=9", nticks); end
        axi_write(5'h00, 32'h0, 4'hF, r);
        held = fnd_cnt;
        for (int i = 0; i < 8; i++) begin
            tick1();
            tests_run++;
            if (fnd_cnt !== held || fnd_tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL disabled_hold got %0d/%b required %0d/0", fnd_cnt, fnd_tick, held);
            end
        end
        axi_read(5'h10, d, r);
        tests_run++;
        if (d !== {18'b0, held} || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL count_read got %h/%b required %h/00", d, r, {18'b0, held});
        end
    endtask

    task automatic test_slverr();
        logic [1:0]  r;
        logic [31:0] d;
        logic [13:0] held = fnd_cnt;
        axi_write(5'h10, 32'h0000FFFF, 4'hF, r);
        tests_run++;
        if (r !== 2'b10 || fnd_cnt !== held) begin
            tests_failed++;
            $display("FAIL ro_write got bresp=%b cnt=%0d required 10/%0d", r, fnd_cnt, held);
        end
        axi_write(5'h1C, 32'h1, 4'hF, r);
        tests_run++;
        if (r !== 2'b10) begin tests_failed++; $display("FAIL unmapped_write got %b required 10", r); end
        axi_read(5'h14, d, r);
        tests_run++;
        if (d !== 32'h0 || r !== 2'b10) begin tests_failed++; $display("FAIL unmapped_read got %h/%b required 0/10", d, r); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  r;
        logic [31:0] d;
        int n = 0;
        awaddr = 5'h0C; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        do begin tick1(); n++; end while (!awready && n < 20);
        tests_run++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL concurrent_accept got aw=%b ar=%b required 1/1", awready, arready);
        end
        tick1();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== {5'b00011, 4'b0000, 32'd3}) begin
                tests_failed++;
                $display("FAIL backpressure cycle%0d aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h required 0 0 0 1 1 00 00 00000003",
                         i, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
            end
            tick1();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tick1();
        bready = 1'b0; rready = 1'b0;
        tests_run++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release got b=%b r=%b required 0/0", bvalid, rvalid);
        end
        axi_read(5'h0C, d, r);
        tests_run++;
        if (d !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL b2b_write_data got %h required deadbeef", d); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  r;
        logic [31:0] d;
        int n = 0;
        axi_write(5'h00, 32'h2, 4'hF, r);
        axi_write(5'h04, 32'd0, 4'hF, r);
        axi_write(5'h08, 32'd100, 4'hF, r);
        axi_write(5'h00, 32'h1, 4'hF, r);
        axi_write(5'h00, 32'h0, 4'hF, r);
        tests_run++;
        if (fnd_cnt !== 14'd3) begin tests_failed++; $display("FAIL prescale0_count got %0d required 3", fnd_cnt); end
        awaddr = 5'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        do begin tick1(); n++; end while (!awready && n < 20);
        tick1();
        awvalid = 1'b0; wvalid = 1'b0;
        tests_run++;
        if (bvalid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_bvalid got %b required 1", bvalid); end
        areset = 1'b1;
        tick1();
        tests_run++;
        if (bvalid !== 1'b0 || fnd_cnt !== 14'd0 || fnd_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got b=%b cnt=%0d tick=%b required 0/0/0", bvalid, fnd_cnt, fnd_tick);
        end
        areset = 1'b0;
        repeat (3) tick1();
        tests_run++;
        if (bvalid !== 1'b0) begin tests_failed++; $display("FAIL no_late_b got %b required 0", bvalid); end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), d, r);
            tests_run++;
            if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_reg%0d got %h required 0", i, d); end
        end
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_rw();
        test_strobe();
        test_count();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
